// File: rtl/adc_sample_conditioner.sv
// Moving-average ADC conditioner: ring-buffer average, scale to mV, restoring divide by 255, double-dabble to BCD.
// Optional peak-code tracking is enabled with `define ADC_COND_PEAK_EN.
module adc_sample_conditioner #(
  parameter int AVG_LOG2 = 3,
  parameter int VREF_MV  = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic [3:0] bcd_thousand,
  output logic [3:0] bcd_hundred,
  output logic [3:0] bcd_tenth,
  output logic [3:0] bcd_unit,
  output logic       bcd_valid,
  output logic       busy,
  output logic       overrun,
  output logic [2:0] dbg_state
`ifdef ADC_COND_PEAK_EN
  , output logic [7:0] peak_code
`endif
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 8 + AVG_LOG2;

  // Handshake: sample_valid is a one-cycle strobe with no ready; it is taken
  // only in IDLE, and any strobe seen elsewhere is dropped and flags overrun.
  typedef enum logic [2:0] {IDLE, ACC, SCALE, DIV, BCD, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        sample_q, sample_d;
  logic [7:0]        ring_q [DEPTH];
  logic [7:0]        ring_d [DEPTH];
  logic [AVG_LOG2-1:0] wp_q, wp_d;
  logic [AVG_LOG2:0] fill_q, fill_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [21:0]       quo_q, quo_d;
  logic [7:0]        rem_q, rem_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [29:0]       dd_q, dd_d;
  logic [15:0]       digits_q, digits_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [8:0]        trial;
  logic [29:0]       dd_adj;
  logic [7:0]        avg;
`ifdef ADC_COND_PEAK_EN
  logic [7:0]        peak_q, peak_d;
`endif

  assign avg = sum_q[SUM_W-1:AVG_LOG2];

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    ring_d    = ring_q;
    wp_d      = wp_q;
    fill_d    = fill_q;
    sum_d     = sum_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    dd_d      = dd_q;
    digits_d  = digits_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    trial     = {rem_q, quo_q[21]};
    dd_adj    = dd_q;
`ifdef ADC_COND_PEAK_EN
    peak_d    = peak_q;
`endif
    if (sample_valid && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          sample_d = sample_in;
          state_d  = ACC;
        end
      end
      ACC: begin
        // Oldest code leaves and newest enters in one expression: never negative.
        sum_d        = sum_q - SUM_W'(ring_q[wp_q]) + SUM_W'(sample_q);
        ring_d[wp_q] = sample_q;
        wp_d         = wp_q + AVG_LOG2'(1);
        if (fill_q != (AVG_LOG2+1)'(DEPTH)) fill_d = fill_q + (AVG_LOG2+1)'(1);
`ifdef ADC_COND_PEAK_EN
        if (sample_q > peak_q) peak_d = sample_q;
`endif
        state_d = SCALE;
      end
      SCALE: begin
        quo_d   = 22'(avg) * 22'(VREF_MV);
        rem_d   = 8'd0;
        cnt_d   = 5'd0;
        state_d = DIV;
      end
      DIV: begin
        // Dividend shifts out of quo_q's MSB while quotient bits shift in at the LSB.
        if (trial >= 9'd255) begin
          rem_d = 8'(trial - 9'd255);
          quo_d = {quo_q[20:0], 1'b1};
        end else begin
          rem_d = trial[7:0];
          quo_d = {quo_q[20:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd21) begin
          cnt_d   = 5'd0;
          dd_d    = {16'd0, quo_d[13:0]};
          state_d = BCD;
        end
      end
      BCD: begin
        for (int i = 0; i < 4; i++) begin
          if (dd_adj[14+4*i +: 4] >= 4'd5) dd_adj[14+4*i +: 4] = dd_adj[14+4*i +: 4] + 4'd3;
        end
        dd_d  = {dd_adj[28:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd13) begin
          cnt_d   = 5'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (fill_q == (AVG_LOG2+1)'(DEPTH)) begin
          digits_d = dd_q[29:14];
          valid_d  = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sample_q  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= 8'd0;
      wp_q      <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      dd_q      <= '0;
      digits_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef ADC_COND_PEAK_EN
      peak_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      ring_q    <= ring_d;
      wp_q      <= wp_d;
      fill_q    <= fill_d;
      sum_q     <= sum_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      dd_q      <= dd_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef ADC_COND_PEAK_EN
      peak_q    <= peak_d;
`endif
    end
  end

  assign bcd_thousand = digits_q[15:12];
  assign bcd_hundred  = digits_q[11:8];
  assign bcd_tenth    = digits_q[7:4];
  assign bcd_unit     = digits_q[3:0];
  assign bcd_valid    = valid_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;
`ifdef ADC_COND_PEAK_EN
  assign peak_code    = peak_q;
`endif

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Bench for adc_sample_conditioner: vector table, randomized samples against a window model,
// plus overrun and mid-conversion reset sequences.
module tb_adc_sample_conditioner;

  localparam int AVG_LOG2 = 3;
  localparam int DEPTH    = 1 << AVG_LOG2;
  localparam int VREF_MV  = 5000;

  logic       clk;
  logic       rst_n;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [3:0] bcd_thousand, bcd_hundred, bcd_tenth, bcd_unit;
  logic       bcd_valid, busy, overrun;
  logic [2:0] dbg_state;
`ifdef ADC_COND_PEAK_EN
  logic [7:0] peak_code;
`endif

  adc_sample_conditioner #(.AVG_LOG2(AVG_LOG2), .VREF_MV(VREF_MV)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .bcd_thousand(bcd_thousand), .bcd_hundred(bcd_hundred), .bcd_tenth(bcd_tenth),
    .bcd_unit(bcd_unit), .bcd_valid(bcd_valid), .busy(busy), .overrun(overrun),
    .dbg_state(dbg_state)
`ifdef ADC_COND_PEAK_EN
    , .peak_code(peak_code)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // behavioural model: last DEPTH codes, fill level, last reported mV
  int win[$];
  int fill;
  int last_mv;
  int peak;

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < DEPTH; i++) win.push_back(0);
    fill = 0;
    last_mv = 0;
    peak = 0;
  endtask

  task automatic model_sample(input int s, output int exp_pulse);
    int sum;
    win.push_back(s);
    void'(win.pop_front());
    if (fill < DEPTH) fill++;
    if (s > peak) peak = s;
    sum = 0;
    foreach (win[i]) sum += win[i];
    exp_pulse = (fill == DEPTH) ? 1 : 0;
    if (exp_pulse == 1) last_mv = ((sum / DEPTH) * VREF_MV) / 255;
  endtask

  function automatic int mv_to_bcd(input int mv);
    return ((mv / 1000) << 12) | (((mv / 100) % 10) << 8) | (((mv / 10) % 10) << 4) | (mv % 10);
  endfunction

  function automatic int dut_bcd();
    return int'({bcd_thousand, bcd_hundred, bcd_tenth, bcd_unit});
  endfunction

  // driver: one strobe, then watch 45 cycles; k counts falling edges after the accepting edge
  task automatic conv(input logic [7:0] s, input int extra_k, input int rst_k,
                      output int pulse_k, output int pulses, output int busy_shape);
    @(negedge clk);
    sample_in = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    pulse_k = -1;
    pulses = 0;
    busy_shape = 0;
    for (int k = 0; k < 45; k++) begin
      if (k > 0) @(negedge clk);
      if (bcd_valid) begin
        pulses++;
        if (pulse_k < 0) pulse_k = k;
      end
      if (k == 0 && busy) busy_shape |= 4;
      if (k == 38 && busy) busy_shape |= 2;
      if (k == 39 && busy) busy_shape |= 1;
      if (k == extra_k) begin
        sample_in = 8'($urandom_range(0, 255));
        sample_valid = 1'b1;
      end
      if (k == extra_k + 1) sample_valid = 1'b0;
      if (k == rst_k) rst_n = 1'b0;
      if (k == rst_k + 2) rst_n = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] sample;
    logic       exp_pulse;
    logic       chk_mv;
    int         exp_mv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int s, input int n, input int final_mv);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.sample = 8'(s);
      v.exp_pulse = 1'b1;
      v.chk_mv = (i == n - 1);
      v.exp_mv = final_mv;
      tbl.push_back(v);
    end
  endtask

  initial begin
    int pk, np, bs, ep;
    int trunc_mv[8];
    vec_t v;
    trunc_mv = '{607, 1235, 1862, 2490, 3117, 3745, 4372, 5000};

    // fresh fill of 255s: first seven silent with digits still 0
    for (int i = 0; i < 7; i++) begin
      v.sample = 8'd255; v.exp_pulse = 1'b0; v.chk_mv = 1'b1; v.exp_mv = 0;
      tbl.push_back(v);
    end
    v.sample = 8'd255; v.exp_pulse = 1'b1; v.chk_mv = 1'b1; v.exp_mv = 5000;
    tbl.push_back(v);
    add(128, 8, 2509);
    add(51, 8, 1000);
    add(0, 8, 0);
    for (int i = 0; i < 8; i++) begin
      v.sample = 8'd255; v.exp_pulse = 1'b1; v.chk_mv = 1'b1; v.exp_mv = trunc_mv[i];
      tbl.push_back(v);
    end

    rst_n = 1'b0;
    sample_in = 8'd0;
    sample_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_digits", dut_bcd(), 0);
    check("reset_bcd_valid", int'(bcd_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_state", int'(dbg_state), 0);
`ifdef ADC_COND_PEAK_EN
    check("reset_peak", int'(peak_code), 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      model_sample(int'(tbl[i].sample), ep);
      conv(tbl[i].sample, -10, -10, pk, np, bs);
      check($sformatf("tbl%0d_pulses", i), np, int'(tbl[i].exp_pulse));
      check($sformatf("tbl%0d_pulse_cycle", i), pk, tbl[i].exp_pulse ? 39 : -1);
      check($sformatf("tbl%0d_busy_shape", i), bs, 6);
      check($sformatf("tbl%0d_digits", i), dut_bcd(),
            mv_to_bcd(tbl[i].chk_mv ? tbl[i].exp_mv : last_mv));
    end

    for (int i = 0; i < 20; i++) begin
      logic [7:0] s;
      s = 8'($urandom_range(0, 255));
      model_sample(int'(s), ep);
      conv(s, -10, -10, pk, np, bs);
      check($sformatf("rnd%0d_pulses", i), np, ep);
      check($sformatf("rnd%0d_digits", i), dut_bcd(), mv_to_bcd(last_mv));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    check("overrun_before", int'(overrun), 0);

    // second strobe at E+5 is dropped and latches overrun
    model_sample(77, ep);
    conv(8'd77, 4, -10, pk, np, bs);
    check("ovr_pulses", np, 1);
    check("ovr_pulse_cycle", pk, 39);
    check("ovr_busy_shape", bs, 6);
    check("ovr_digits", dut_bcd(), mv_to_bcd(last_mv));
    check("ovr_flag", int'(overrun), 1);
    model_sample(200, ep);
    conv(8'd200, -10, -10, pk, np, bs);
    check("ovr_sticky", int'(overrun), 1);
    check("ovr_next_digits", dut_bcd(), mv_to_bcd(last_mv));

    // reset mid-conversion: no pulse, fill restarts from empty
    conv(8'd255, -10, 20, pk, np, bs);
    model_reset();
    check("midrst_pulses", np, 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_digits", dut_bcd(), 0);
    for (int i = 0; i < 8; i++) begin
      model_sample(180, ep);
      conv(8'd180, -10, -10, pk, np, bs);
      check($sformatf("refill%0d_pulses", i), np, ep);
      check($sformatf("refill%0d_digits", i), dut_bcd(), mv_to_bcd(last_mv));
    end

`ifdef ADC_COND_PEAK_EN
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_sample(10, ep);
    conv(8'd10, -10, -10, pk, np, bs);
    model_sample(200, ep);
    conv(8'd200, -10, -10, pk, np, bs);
    model_sample(30, ep);
    conv(8'd30, -10, -10, pk, np, bs);
    check("peak_code", int'(peak_code), peak);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
